// File: rtl/vga_sync_out.sv
// VGA raster timing and output register stage.
// Counters drive pixel coordinates; syncs and colour are aligned to the draw pipeline.
module vga_sync_out #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  RGBIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        frameTick,
  output logic        hsyncN,
  output logic        vsyncN,
  output logic        blankN,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_MAX = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_MAX = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT = 11'(V_ACTIVE);
  localparam logic [10:0] H_SS  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SE  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SS  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SE  = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Timing bundle ordering: {hsync_n, vsync_n, active}; idle is 3'b110.
  localparam logic [2:0] TIM_IDLE = 3'b110;

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        frame_tick_q, frame_tick_d;
  logic        hsync_n_q, hsync_n_d;
  logic        vsync_n_q, vsync_n_d;
  logic        blank_n_q, blank_n_d;
  logic [7:0]  red_q, red_d;
  logic [7:0]  green_q, green_d;
  logic [7:0]  blue_q, blue_d;

  logic [2:0]  tim_raw;
  logic [2:0]  tim_dly;

  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_MAX) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + 11'd1;
    end
    frame_tick_d = (h_cnt_q == '0) && (v_cnt_q == V_ACT);
  end

  always_comb begin
    tim_raw    = TIM_IDLE;
    tim_raw[2] = ~((h_cnt_q >= H_SS) && (h_cnt_q < H_SE));
    tim_raw[1] = ~((v_cnt_q >= V_SS) && (v_cnt_q < V_SE));
    tim_raw[0] = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  end

  generate
    if (PIPE_DELAY == 0) begin : g_bypass
      assign tim_dly = tim_raw;
    end else begin : g_pipe
      logic [2:0] dly_q [PIPE_DELAY];
      logic [2:0] dly_d [PIPE_DELAY];

      always_comb begin
        dly_d[0] = tim_raw;
        for (int i = 1; i < PIPE_DELAY; i++)
          dly_d[i] = dly_q[i-1];
      end

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          for (int i = 0; i < PIPE_DELAY; i++)
            dly_q[i] <= TIM_IDLE;
        end else begin
          for (int i = 0; i < PIPE_DELAY; i++)
            dly_q[i] <= dly_d[i];
        end
      end

      assign tim_dly = dly_q[PIPE_DELAY-1];
    end
  endgenerate

  // RGBIn arrives aligned with the delayed timing, so it is masked here.
  always_comb begin
    hsync_n_d = tim_dly[2];
    vsync_n_d = tim_dly[1];
    blank_n_d = tim_dly[0];
    red_d     = '0;
    green_d   = '0;
    blue_d    = '0;
    if (tim_dly[0]) begin
      red_d   = {RGBIn[7:5], RGBIn[7:5], RGBIn[7:6]};
      green_d = {RGBIn[4:2], RGBIn[4:2], RGBIn[4:3]};
      blue_d  = {4{RGBIn[1:0]}};
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      frame_tick_q <= 1'b0;
      hsync_n_q    <= 1'b1;
      vsync_n_q    <= 1'b1;
      blank_n_q    <= 1'b0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
    end else begin
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      frame_tick_q <= frame_tick_d;
      hsync_n_q    <= hsync_n_d;
      vsync_n_q    <= vsync_n_d;
      blank_n_q    <= blank_n_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
    end
  end

  assign pixelX    = h_cnt_q;
  assign pixelY    = v_cnt_q;
  assign frameTick = frame_tick_q;
  assign hsyncN    = hsync_n_q;
  assign vsyncN    = vsync_n_q;
  assign blankN    = blank_n_q;
  assign red       = red_q;
  assign green     = green_q;
  assign blue      = blue_q;

endmodule

// File: tb/tb_vga_sync_out.sv
// Randomized bench for vga_sync_out: full 640x480 geometry plus two
// reduced geometries (PIPE_DELAY 0 and 3) against a cycle-index model.
module tb_vga_sync_out;

  typedef struct {
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
    int d;
  } geo_t;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        ft;
    logic        hs;
    logic        vs;
    logic        bl;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } obs_t;

  localparam geo_t G_FULL = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
  localparam geo_t G_D0   = '{16, 4, 6, 6, 12, 2, 2, 3, 0};
  localparam geo_t G_D3   = '{16, 4, 6, 6, 12, 2, 2, 3, 3};

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [7:0] RGBIn = 8'hFF;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  obs_t o_full, o_d0, o_d3;

  logic [10:0] fx, fy, ax, ay, bx, by;
  logic        fft, fhs, fvs, fbl, aft, ahs, avs, abl, bft, bhs, bvs, bbl;
  logic [7:0]  fr, fg, fb, ar, ag, ab, br, bg, bb;

  vga_sync_out #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .PIPE_DELAY(1)
  ) u_full (
    .clk(clk), .resetN(resetN), .RGBIn(RGBIn),
    .pixelX(fx), .pixelY(fy), .frameTick(fft),
    .hsyncN(fhs), .vsyncN(fvs), .blankN(fbl),
    .red(fr), .green(fg), .blue(fb)
  );

  vga_sync_out #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .PIPE_DELAY(0)
  ) u_d0 (
    .clk(clk), .resetN(resetN), .RGBIn(RGBIn),
    .pixelX(ax), .pixelY(ay), .frameTick(aft),
    .hsyncN(ahs), .vsyncN(avs), .blankN(abl),
    .red(ar), .green(ag), .blue(ab)
  );

  vga_sync_out #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .PIPE_DELAY(3)
  ) u_d3 (
    .clk(clk), .resetN(resetN), .RGBIn(RGBIn),
    .pixelX(bx), .pixelY(by), .frameTick(bft),
    .hsyncN(bhs), .vsyncN(bvs), .blankN(bbl),
    .red(br), .green(bg), .blue(bb)
  );

  assign o_full = {fx, fy, fft, fhs, fvs, fbl, fr, fg, fb};
  assign o_d0   = {ax, ay, aft, ahs, avs, abl, ar, ag, ab};
  assign o_d3   = {bx, by, bft, bhs, bvs, bbl, br, bg, bb};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Channel expansion as ideal scaling rounded to nearest.
  function automatic logic [7:0] exp3(input logic [2:0] v);
    return 8'((int'(v) * 255 + 3) / 7);
  endfunction

  function automatic logic [7:0] exp2(input logic [1:0] v);
    return 8'(int'(v) * 85);
  endfunction

  // k = clock edges since reset release; rgb = RGBIn seen at edge k.
  function automatic obs_t model(input geo_t g, input int k,
                                 input logic [7:0] rgb);
    int ht, vt, fr_len, j, x, y, hss, vss;
    obs_t e;
    ht     = g.ha + g.hf + g.hs + g.hb;
    vt     = g.va + g.vf + g.vs + g.vb;
    fr_len = ht * vt;
    hss    = g.ha + g.hf;
    vss    = g.va + g.vf;
    e      = '0;
    e.x    = 11'((k % fr_len) % ht);
    e.y    = 11'((k % fr_len) / ht);
    e.hs   = 1'b1;
    e.vs   = 1'b1;
    j      = k - 1 - g.d;
    if (k >= 1 && j >= 0) begin
      x    = (j % fr_len) % ht;
      y    = (j % fr_len) / ht;
      e.hs = !(x >= hss && x < hss + g.hs);
      e.vs = !(y >= vss && y < vss + g.vs);
      e.bl = (x < g.ha) && (y < g.va);
      if (e.bl) begin
        e.r = exp3(rgb[7:5]);
        e.g = exp3(rgb[4:2]);
        e.b = exp2(rgb[1:0]);
      end
    end
    e.ft = (k >= 1) && (((k - 1) % fr_len) == g.va * ht);
    return e;
  endfunction

  task automatic check_dut(input string nm, input geo_t g, input obs_t o,
                           input int k, input logic [7:0] rgb);
    obs_t e;
    e = model(g, k, rgb);
    chk({nm, ".pixelX"},    32'(o.x),  32'(e.x));
    chk({nm, ".pixelY"},    32'(o.y),  32'(e.y));
    chk({nm, ".frameTick"}, 32'(o.ft), 32'(e.ft));
    chk({nm, ".hsyncN"},    32'(o.hs), 32'(e.hs));
    chk({nm, ".vsyncN"},    32'(o.vs), 32'(e.vs));
    chk({nm, ".blankN"},    32'(o.bl), 32'(e.bl));
    chk({nm, ".red"},       32'(o.r),  32'(e.r));
    chk({nm, ".green"},     32'(o.g),  32'(e.g));
    chk({nm, ".blue"},      32'(o.b),  32'(e.b));
  endtask

  task automatic check_all(input int k, input logic [7:0] rgb);
    check_dut("full", G_FULL, o_full, k, rgb);
    check_dut("d0",   G_D0,   o_d0,   k, rgb);
    check_dut("d3",   G_D3,   o_d3,   k, rgb);
  endtask

  function automatic logic [7:0] pick_rgb();
    logic [7:0] tbl [5];
    tbl = '{8'hE0, 8'h4A, 8'h03, 8'hFF, 8'h1C};
    if ($urandom_range(0, 2) == 0)
      return tbl[$urandom_range(0, 4)];
    return 8'($urandom);
  endfunction

  task automatic run_cycles(input int n);
    int k;
    logic [7:0] rgb;
    k     = 0;
    rgb   = RGBIn;
    check_all(k, rgb);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k++;
      check_all(k, rgb);
      rgb   = pick_rgb();
      RGBIn = rgb;
    end
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all(0, RGBIn);
    end
  endtask

  initial begin
    RGBIn  = 8'hFF;
    resetN = 1'b0;
    hold_reset(4);
    resetN = 1'b1;
    run_cycles(2500);

    // Asynchronous reset landing between clock edges.
    #2 resetN = 1'b0;
    RGBIn = 8'hFF;
    #1 check_all(0, RGBIn);
    hold_reset(3);
    resetN = 1'b1;
    run_cycles(2000);

    @(posedge clk);
    #3 resetN = 1'b0;
    #1 check_all(0, RGBIn);
    hold_reset(2);
    resetN = 1'b1;
    run_cycles(1400);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_out.md
Name: vga_sync_out

Overview:
Final VGA output stage, directly downstream of the objects multiplexer. Generates the 640x480@60 raster timing and drives the pixel coordinates that all drawing objects consume. Receives the multiplexer's registered 8-bit RGB332 pixel and expands it to 8-bit-per-channel DAC colour. Aligns hsync, vsync and blanking with the pipeline latency of the drawing path.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
PIPE_DELAY, 1, clocks from pixelX/pixelY to the matching RGBIn (legal range 0..4)

Ports:
clk  in  1  pixel clock, 25.175 MHz; one pixel per cycle
resetN  in  1  asynchronous reset, active-low
RGBIn  in  8  RGB332 pixel from the objects multiplexer: R=[7:5], G=[4:2], B=[1:0]
pixelX  out  11  current horizontal counter, 0..H_TOTAL-1
pixelY  out  11  current vertical counter, 0..V_TOTAL-1
frameTick  out  1  one-clock pulse at start of vertical blanking
hsyncN  out  1  horizontal sync, active-low
vsyncN  out  1  vertical sync, active-low
blankN  out  1  high when the output pixel is visible
red  out  8  DAC red
green  out  8  DAC green
blue  out  8  DAC blue

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- hCnt increments every clk and wraps from H_TOTAL-1 to 0. On wrap, vCnt increments; vCnt wraps from V_TOTAL-1 to 0 only when hCnt also wraps.
- pixelX and pixelY equal hCnt and vCnt. They are driven directly from the counter registers, with no extra delay.
- Raw timing, combinational from the counters:
  - hs_raw is low when H_ACTIVE+H_FP <= hCnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw is low when V_ACTIVE+V_FP <= vCnt < V_ACTIVE+V_FP+V_SYNC (490..491).
  - act_raw is high when hCnt < H_ACTIVE and vCnt < V_ACTIVE.
- Delay line: hs_raw, vs_raw and act_raw pass through PIPE_DELAY register stages. With PIPE_DELAY=0 the stages are bypassed.
- Output register: every clk, hsyncN, vsyncN and blankN take the delayed values.
  - When delayed act is 1, red/green/blue take the expanded RGBIn; otherwise they are 0.
  - Total latency from a pixelX/pixelY value to its hsyncN/vsyncN/blankN/colour is PIPE_DELAY+1 clocks.
- Colour expansion by bit replication:
  - red = {R,R,R[2:1]}
  - green = {G,G,G[2:1]}
  - blue = {B,B,B,B}
  - So 3'b111 maps to 8'hFF and 0 maps to 8'h00.
- frameTick is a registered one-clock pulse, asserted in the clock after the counters reach (hCnt==0, vCnt==V_ACTIVE). Exactly one pulse per frame. It is not delayed by PIPE_DELAY.
- Reset (asynchronous, any time, including mid-line or mid-frame):
  - hCnt and vCnt = 0; frameTick = 0.
  - hsyncN and vsyncN = 1; blankN = 0; red, green and blue = 0.
  - All delay-line stages are loaded with the inactive values (sync 1, act 0).
- After resetN deasserts, the first cycle presents pixelX=0, pixelY=0. The first visible output pixel appears on blankN PIPE_DELAY+1 clocks later.
- RGBIn is ignored (masked to zero) whenever the delayed act is 0. This applies even when RGBIn is nonzero.

Test Plan:
- Reset: hold resetN=0 with RGBIn=8'hFF -> hsyncN=1, vsyncN=1, blankN=0, RGB=0, pixelX=pixelY=0, frameTick=0. Release -> pixelX counts 0,1,2...; blankN rises exactly 2 clocks later (PIPE_DELAY=1).
- Line timing, PIPE_DELAY=1: hsyncN is low for exactly 96 clocks, starting 2 clocks after pixelX=656. blankN is high for 640 clocks per visible line. Line period is 800 clocks.
- Frame timing: frameTick pulses once every 420000 clocks, one clock after pixelY becomes 480 with pixelX=0. vsyncN is low for 1600 clocks, starting 2 clocks after pixelY=490, pixelX=0. Lines 480..524 have blankN=0 throughout.
- Colour expansion: RGBIn=8'hE0 during active -> red=FF, green=00, blue=00. RGBIn=8'h4A -> red=49, green=49, blue=AA. RGBIn=8'h03 -> blue=FF.
- Blanking mask: RGBIn=8'hFF constant -> RGB outputs are 0 on every cycle where blankN=0, including pixelX 640..799 (after delay).
- Reset mid-frame: assert resetN at pixelX=300, pixelY=200 -> outputs go to reset values asynchronously. After release the counters restart at (0,0) with no spurious frameTick or sync pulse. Repeat with PIPE_DELAY=0 and 3 to check latencies of 1 and 4 clocks.
